// File: rtl/tunnel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tunnel_pkg
// Description : Shared wall codes, FSM encoding and playfield constants for
//               the tunnel wall generator and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package tunnel_pkg;

    localparam int NUM_ROWS = 120;
    localparam int NUM_COLS = 160;

    localparam logic [1:0] WALL_GAP   = 2'b00;
    localparam logic [1:0] WALL_LEFT  = 2'b01;
    localparam logic [1:0] WALL_RIGHT = 2'b10;
    localparam logic [1:0] WALL_EDGE  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_GEN  = 2'd2
    } state_e;

    // Edge columns win over the inside/outside classification.
    function automatic logic [1:0] wall_code(input logic [7:0] ccol,
                                             input logic [7:0] left,
                                             input logic [7:0] right);
        logic [1:0] code;
        code = WALL_GAP;
        if ((ccol == left) || (ccol == right)) begin
            code = WALL_EDGE;
        end else if (ccol < left) begin
            code = WALL_LEFT;
        end else if (ccol > right) begin
            code = WALL_RIGHT;
        end
        return code;
    endfunction

endpackage : tunnel_pkg
`default_nettype wire

// File: rtl/tunnel_row_ram.sv
`default_nettype none
// ============================================================================
// Module      : tunnel_row_ram
// Description : Simple dual-port row buffer, one write port and one
//               registered read port (read-during-write returns old data).
// Revision    : 1.0 - initial release
// ============================================================================
module tunnel_row_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule : tunnel_row_ram
`default_nettype wire

// File: rtl/tunnel_wall_gen.sv
`default_nettype none
// ============================================================================
// Module      : tunnel_wall_gen
// Description : Scrolling tunnel wall generator: circular row buffer, scroll
//               FSM, drift/clamp row synthesis and per-pixel wall lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module tunnel_wall_gen
    import tunnel_pkg::*;
#(
    parameter int ROWS         = NUM_ROWS,
    parameter int COLS         = NUM_COLS,
    parameter int INIT_WIDTH   = 64,
    parameter int MIN_GAP      = 24,
    parameter int SHRINK_EVERY = 16,
    parameter int PROBE_ROW    = 110
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [9:0] Pixel_row,
    input  logic [9:0] Pixel_column,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic [7:0] randomized_value,
    output logic [1:0] wall,
    output logic [7:0] probe_left,
    output logic [7:0] probe_right,
    output logic       ready
);

    localparam logic [7:0] INIT_L     = 8'(COLS / 2 - INIT_WIDTH / 2);
    localparam logic [7:0] INIT_R     = 8'(COLS / 2 + INIT_WIDTH / 2 - 1);
    localparam logic [8:0] R_MAX      = 9'(COLS - 2);
    localparam logic [7:0] EDGE_SUM   = 8'(COLS - 1);
    localparam logic [7:0] W_INIT     = 8'(INIT_WIDTH);
    localparam logic [7:0] W_MIN      = 8'(MIN_GAP);
    localparam int         SC_W       = (SHRINK_EVERY > 1) ? $clog2(SHRINK_EVERY) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SHRINK_EVERY - 1);
    localparam logic [9:0] LAST_ROW   = 10'(ROWS * 4 - 1);
    localparam logic [9:0] LAST_COL   = 10'(COLS * 4 - 1);
    localparam logic [7:0] PROBE_CROW = 8'(PROBE_ROW);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [6:0]      head_q;
    logic [6:0]      init_cnt_q;
    logic [2:0]      frame_cnt_q;
    logic [SC_W-1:0] scroll_cnt_q;
    logic [7:0]      width_q;
    logic [7:0]      top_l_q;
    logic [7:0]      top_r_q;
    logic            ready_q;

    // ------------------------------------------------------------------
    // Lookup pipeline state
    // ------------------------------------------------------------------
    logic [7:0]      ccol_q;
    logic            probe_hit_q;
    logic [1:0]      wall_q;
    logic [7:0]      probe_l_q;
    logic [7:0]      probe_r_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [7:0]      w_crow;
    logic [7:0]      w_ccol;
    logic            w_frame_end;
    logic [2:0]      w_frame_lim;
    logic [6:0]      w_rd_addr;
    logic [15:0]     w_rd_data;
    logic [7:0]      w_rd_l;
    logic [7:0]      w_rd_r;
    logic [8:0]      w_l_sum;
    logic [8:0]      w_r_sum;
    logic [7:0]      new_l_d;
    logic [7:0]      new_r_d;
    logic            w_we;
    logic [6:0]      w_waddr;
    logic [15:0]     w_wdata;
    logic            w_unused;

    assign w_crow      = Pixel_row[9:2];
    assign w_ccol      = Pixel_column[9:2];
    assign w_frame_end = (Pixel_row == LAST_ROW) && (Pixel_column == LAST_COL);
    // Period limit is (8 >> speed) - 1, i.e. 7, 3, 1, 0.
    assign w_frame_lim = 3'd7 >> speed;
    assign w_rd_addr   = head_q + w_crow[6:0];
    assign w_rd_l      = w_rd_data[15:8];
    assign w_rd_r      = w_rd_data[7:0];
    assign w_unused    = ^{w_crow[7], randomized_value[7:2]};

    // ------------------------------------------------------------------
    // New top row from the current top row, drift and gap width
    // ------------------------------------------------------------------
    always_comb begin
        w_l_sum = {1'b0, top_l_q};
        case (randomized_value[1:0])
            2'b00:   w_l_sum = {1'b0, top_l_q} - 9'd1;
            2'b11:   w_l_sum = {1'b0, top_l_q} + 9'd1;
            default: w_l_sum = {1'b0, top_l_q};
        endcase

        new_l_d = w_l_sum[7:0];
        if (w_l_sum == 9'd0) begin
            new_l_d = 8'd1;
        end

        w_r_sum = {1'b0, new_l_d} + {1'b0, width_q} - 9'd1;
        new_r_d = w_r_sum[7:0];
        // Right overflow pins the right edge and pulls the left edge in.
        if (w_r_sum > R_MAX) begin
            new_r_d = R_MAX[7:0];
            new_l_d = EDGE_SUM - width_q;
        end
    end

    // ------------------------------------------------------------------
    // Buffer write port: INIT sweep or one GEN write per scroll
    // ------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = init_cnt_q;
        w_wdata = {INIT_L, INIT_R};
        case (state_q)
            ST_INIT: begin
                w_we = 1'b1;
            end
            ST_GEN: begin
                w_we    = 1'b1;
                w_waddr = head_q - 7'd1;
                w_wdata = {new_l_d, new_r_d};
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    tunnel_row_ram #(
        .DEPTH  (128),
        .ADDR_W (7),
        .DATA_W (16)
    ) u_row_ram (
        .clk_i   (clock),
        .we_i    (w_we),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .raddr_i (w_rd_addr),
        .rdata_o (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Scroll FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ST_INIT;
            head_q       <= 7'd0;
            init_cnt_q   <= 7'd0;
            frame_cnt_q  <= 3'd0;
            scroll_cnt_q <= '0;
            width_q      <= W_INIT;
            top_l_q      <= INIT_L;
            top_r_q      <= INIT_R;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 7'd1;
                    if (init_cnt_q == 7'd127) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_frame_end && run) begin
                        // >= so a speed increase mid-period fires promptly.
                        if (frame_cnt_q >= w_frame_lim) begin
                            frame_cnt_q <= 3'd0;
                            state_q     <= ST_GEN;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 3'd1;
                        end
                    end
                end
                ST_GEN: begin
                    head_q  <= head_q - 7'd1;
                    top_l_q <= new_l_d;
                    top_r_q <= new_r_d;
                    state_q <= ST_IDLE;
                    if (scroll_cnt_q == SC_LAST) begin
                        scroll_cnt_q <= '0;
                        width_q      <= (width_q >= W_MIN + 8'd2) ? width_q - 8'd2 : W_MIN;
                    end else begin
                        scroll_cnt_q <= scroll_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: stage 1 is the RAM read, stage 2 the compare
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            ccol_q      <= 8'd0;
            probe_hit_q <= 1'b0;
            wall_q      <= WALL_GAP;
            probe_l_q   <= INIT_L;
            probe_r_q   <= INIT_R;
        end else begin
            ccol_q      <= w_ccol;
            probe_hit_q <= (w_crow == PROBE_CROW) && (w_ccol == 8'd0);
            wall_q      <= ready_q ? wall_code(ccol_q, w_rd_l, w_rd_r) : WALL_GAP;
            if (ready_q && probe_hit_q) begin
                probe_l_q <= w_rd_l;
                probe_r_q <= w_rd_r;
            end
        end
    end

    assign wall        = wall_q;
    assign probe_left  = probe_l_q;
    assign probe_right = probe_r_q;
    assign ready       = ready_q;

endmodule : tunnel_wall_gen
`default_nettype wire

// File: tb/tb_tunnel_wall_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tunnel_wall_gen
// Description : Self-checking bench for tunnel_wall_gen against a row-queue
//               model of the scrolling tunnel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tunnel_wall_gen;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] Pixel_row = 10'd0;
    logic [9:0] Pixel_column = 10'd0;
    logic       run = 1'b0;
    logic [1:0] speed = 2'd3;
    logic [7:0] randomized_value = 8'd0;
    logic [1:0] wall;
    logic [7:0] probe_left;
    logic [7:0] probe_right;
    logic       ready;

    tunnel_wall_gen dut (
        .clock            (clock),
        .rst              (rst),
        .Pixel_row        (Pixel_row),
        .Pixel_column     (Pixel_column),
        .run              (run),
        .speed            (speed),
        .randomized_value (randomized_value),
        .wall             (wall),
        .probe_left       (probe_left),
        .probe_right      (probe_right),
        .ready            (ready)
    );

    always #20 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: index 0 of the queues is the row shown at the top of the screen.
    int ml[$];
    int mr[$];
    int m_scrolls;
    int m_fcnt;

    typedef struct {
        int row;
        int col;
        int exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ml.delete();
        mr.delete();
        for (int i = 0; i < 128; i++) begin
            ml.push_back(48);
            mr.push_back(111);
        end
        m_scrolls = 0;
        m_fcnt    = 0;
    endtask

    function automatic int model_width();
        int w;
        w = 64 - 2 * (m_scrolls / 16);
        if (w < 24) w = 24;
        return w;
    endfunction

    function automatic int exp_wall(int crow, int ccol);
        int l, r;
        l = ml[crow];
        r = mr[crow];
        if (ccol == l || ccol == r) return 3;
        if (ccol < l) return 1;
        if (ccol > r) return 2;
        return 0;
    endfunction

    task automatic model_scroll(int rv);
        int nl, nr, drift, w;
        w     = model_width();
        drift = (rv % 4 == 0) ? -1 : ((rv % 4 == 3) ? 1 : 0);
        nl    = ml[0] + drift;
        if (nl < 1) nl = 1;
        nr = nl + w - 1;
        if (nr > 158) begin
            nr = 158;
            nl = 159 - w;
        end
        ml.push_front(nl);
        mr.push_front(nr);
        void'(ml.pop_back());
        void'(mr.pop_back());
        m_scrolls++;
    endtask

    task automatic do_reset(int hold);
        rst = 1'b1;
        repeat (hold) @(posedge clock);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_wall"}, int'(wall), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_probe_left"}, int'(probe_left), 48);
        chk({tag, "_probe_right"}, int'(probe_right), 111);
    endtask

    // ready must stay low for exactly 127 edges after release and rise on the 128th.
    task automatic ready_timing(string tag);
        int early, forced;
        early  = 0;
        forced = 0;
        Pixel_row    = 10'd0;
        Pixel_column = 10'd0;
        for (int i = 1; i < 128; i++) begin
            @(posedge clock);
            #1;
            if (ready) early++;
            if (wall != 2'b00) forced++;
        end
        chk({tag, "_ready_low_cycles"}, early, 0);
        chk({tag, "_wall_gap_while_init"}, forced, 0);
        @(posedge clock);
        #1;
        chk({tag, "_ready_rise"}, int'(ready), 1);
    endtask

    task automatic look(int row, int col, output int got);
        Pixel_row    = 10'(row);
        Pixel_column = 10'(col);
        repeat (2) @(posedge clock);
        #1;
        got = int'(wall);
    endtask

    task automatic check_pixel(int crow, int ccol);
        int got;
        look(4 * crow + int'($urandom_range(0, 3)), 4 * ccol, got);
        chk($sformatf("wall_r%0d_c%0d", crow, ccol), got, exp_wall(crow, ccol));
    endtask

    task automatic check_row(int crow);
        int l, r, c;
        int cols[6];
        l = ml[crow];
        r = mr[crow];
        cols = '{l - 1, l, l + 1, r - 1, r, r + 1};
        foreach (cols[i]) begin
            c = cols[i];
            if (c < 0) c = 0;
            if (c > 159) c = 159;
            check_pixel(crow, c);
        end
    endtask

    task automatic check_probe();
        int got;
        look(440, 0, got);
        chk("probe_left", int'(probe_left), ml[110]);
        chk("probe_right", int'(probe_right), mr[110]);
    endtask

    // One frame_end pixel followed by the GEN slot.
    task automatic frame();
        Pixel_row    = 10'd479;
        Pixel_column = 10'd639;
        @(posedge clock);
        #1;
        Pixel_row    = 10'd0;
        Pixel_column = 10'd0;
        if (run) begin
            if (m_fcnt >= (8 >> speed) - 1) begin
                m_fcnt = 0;
                model_scroll(int'(randomized_value));
            end else begin
                m_fcnt++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int got;

        tbl[0] = '{0,   0,   1};
        tbl[1] = '{0,   188, 1};
        tbl[2] = '{0,   192, 3};
        tbl[3] = '{1,   196, 0};
        tbl[4] = '{2,   320, 0};
        tbl[5] = '{0,   444, 3};
        tbl[6] = '{3,   448, 2};
        tbl[7] = '{0,   636, 2};

        // Reset and initialisation sweep
        do_reset(2);
        check_reset_outputs("reset");
        ready_timing("init");

        foreach (tbl[i]) begin
            look(tbl[i].row, tbl[i].col, got);
            chk($sformatf("table%0d_r%0d_c%0d", i, tbl[i].row, tbl[i].col), got, tbl[i].exp);
        end
        check_probe();

        // Frozen tunnel
        run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            randomized_value = 8'($urandom);
            frame();
        end
        check_row(0);
        check_row(1);

        // Rightward drift, one scroll per frame
        run = 1'b1;
        speed = 2'd3;
        randomized_value = 8'h03;
        for (int k = 0; k < 5; k++) begin
            frame();
            check_row(0);
        end
        check_row(1);
        check_row(4);

        // Left saturation at L = 1
        randomized_value = 8'h00;
        for (int k = 0; k < 60; k++) frame();
        check_row(0);
        check_row(2);

        // Right saturation at R = 158
        randomized_value = 8'h03;
        for (int k = 0; k < 140; k++) frame();
        check_row(0);
        check_row(1);
        check_probe();

        // Slow period: speed 1 scrolls every 4th frame
        speed = 2'd1;
        randomized_value = 8'h00;
        for (int k = 0; k < 6; k++) begin
            frame();
            check_pixel(0, ml[0]);
        end

        // Long run so the gap width reaches its floor
        speed = 2'd3;
        for (int k = 0; k < 350; k++) begin
            randomized_value = 8'($urandom);
            frame();
        end
        check_row(0);
        check_row(1);
        check_probe();

        // Randomized run, speed and drift
        for (int k = 0; k < 150; k++) begin
            speed            = 2'($urandom_range(0, 3));
            run              = ($urandom_range(0, 3) != 0);
            randomized_value = 8'($urandom);
            frame();
            check_pixel(int'($urandom_range(0, 119)), int'($urandom_range(0, 159)));
            if (k % 15 == 0) begin
                check_row(int'($urandom_range(0, 119)));
                check_probe();
            end
        end

        // Reset in the middle of the init sweep
        run = 1'b0;
        do_reset(2);
        repeat (60) @(posedge clock);
        #1;
        do_reset(1);
        check_reset_outputs("midinit");
        ready_timing("reinit");
        check_probe();
        check_row(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_tunnel_wall_gen
`default_nettype wire
